wm_program_controller: RTL and testbench

//  Parametrised successor washing-machine sequencer. Runs four selectable programmes through

---
 rtl/wm_pkg.sv | 75 +++++++
 rtl/wm_phase_timer.sv | 29 ++
 rtl/wm_program_controller.sv | 188 ++++++++++++++++++
 tb/tb_wm_program_controller.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared types for the washing-machine sequencer: state codes, programme codes,
// actuator bundle and the per-state actuator decode.
package wm_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned PROG_W  = 2;
  localparam int unsigned RINSE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FILL   = 4'd1,
    ST_HEAT   = 4'd2,
    ST_WASH   = 4'd3,
    ST_DRAIN  = 4'd4,
    ST_RINSE  = 4'd5,
    ST_SPIN   = 4'd6,
    ST_DONE   = 4'd7,
    ST_PAUSED = 4'd8,
    ST_FAULT  = 4'd9
  } wm_state_e;

  typedef enum logic [PROG_W-1:0] {
    PROG_QUICK      = 2'b00,
    PROG_NORMAL     = 2'b01,
    PROG_HEAVY      = 2'b10,
    PROG_RINSE_SPIN = 2'b11
  } wm_prog_e;

  typedef struct packed {
    logic door_lock;
    logic water_valve;
    logic detergent_hatch;
    logic water_heater;
    logic drum_motor;
    logic water_pump;
  } wm_act_t;

  // Actuator pattern for a state; hatch_en gates the detergent hatch during FILL.
  function automatic wm_act_t act_decode(input wm_state_e st, input logic hatch_en);
    wm_act_t a;
    a = '0;
    case (st)
      ST_FILL: begin
        a.door_lock       = 1'b1;
        a.water_valve     = 1'b1;
        a.detergent_hatch = hatch_en;
      end
      ST_HEAT: begin
        a.door_lock    = 1'b1;
        a.water_heater = 1'b1;
      end
      ST_WASH, ST_RINSE: begin
        a.door_lock  = 1'b1;
        a.drum_motor = 1'b1;
      end
      ST_DRAIN: begin
        a.door_lock  = 1'b1;
        a.water_pump = 1'b1;
      end
      ST_SPIN: begin
        a.door_lock  = 1'b1;
        a.drum_motor = 1'b1;
        a.water_pump = 1'b1;
      end
      ST_PAUSED: a.door_lock = 1'b1;
      ST_FAULT: begin
        a.door_lock  = 1'b1;
        a.water_pump = 1'b1;
      end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Saturating phase counter with clear/enable (hold when disabled) and a
// terminal compare used for both phase lengths and fill/heat timeouts.
module wm_phase_timer #(
  parameter int unsigned TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] term,
  output logic               at_term_c
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + TIMER_W'(1);
    end
  end

  // >= so a phase resumed after a pause on its last cycle still completes
  assign at_term_c = (count_q >= term);

endmodule

// File: rtl/wm_program_controller.sv
// Washing-machine programme sequencer: FILL/HEAT/WASH/DRAIN/RINSE/SPIN with
// pause/resume, door interlock, fill/heat timeouts and a latched FAULT.
module wm_program_controller
  import wm_pkg::*;
#(
  parameter int unsigned TIMER_W   = 16,
  parameter int unsigned WASH_CYC  = 40,
  parameter int unsigned RINSE_CYC = 20,
  parameter int unsigned DRAIN_CYC = 10,
  parameter int unsigned SPIN_CYC  = 30,
  parameter int unsigned FILL_TMO  = 100,
  parameter int unsigned HEAT_TMO  = 100,
  parameter int unsigned RINSES    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROG_W-1:0]  SELECTOR,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               DOOR_CLOSED,
  input  logic               WATER_LEVEL_SENSOR,
  input  logic               TEMP_SENSOR,
  output logic               DOOR_LOCK,
  output logic               WATER_VALVE,
  output logic               DETERGENT_HATCH,
  output logic               WATER_HEATER,
  output logic               DRUM_MOTOR,
  output logic               WATER_PUMP,
  output logic [STATE_W-1:0] CURRENT_STATE,
  output logic [RINSE_W-1:0] RINSE_LEFT,
  output logic               DONE,
  output logic               FAULT
);

  wm_state_e          state_q, state_d;
  wm_state_e          saved_q, saved_d;
  wm_prog_e           prog_q, prog_d;
  logic               first_q, first_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d;
  wm_act_t            act_q, act_d;
  logic               done_q, fault_q;

  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_at_term_c;
  logic [TIMER_W-1:0] tmr_term;

  // Terminal count of the current phase (length or timeout), minus one
  always_comb begin
    tmr_term = '1;
    case (state_q)
      ST_FILL:  tmr_term = TIMER_W'(FILL_TMO - 1);
      ST_HEAT:  tmr_term = TIMER_W'(HEAT_TMO - 1);
      ST_WASH:  tmr_term = (prog_q == PROG_HEAVY) ? TIMER_W'(2 * WASH_CYC - 1)
                                                  : TIMER_W'(WASH_CYC - 1);
      ST_DRAIN: tmr_term = TIMER_W'(DRAIN_CYC - 1);
      ST_RINSE: tmr_term = TIMER_W'(RINSE_CYC - 1);
      ST_SPIN:  tmr_term = TIMER_W'(SPIN_CYC - 1);
      default:  tmr_term = '1;
    endcase
  end

  wm_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .term      (tmr_term),
    .at_term_c (tmr_at_term_c)
  );

  // Next-state, programme latch, rinse counter and timer control
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    prog_d  = prog_q;
    first_d = first_q;
    rinse_d = rinse_q;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && DOOR_CLOSED) begin
          state_d = ST_FILL;
          prog_d  = wm_prog_e'(SELECTOR);
          first_d = 1'b1;
          case (wm_prog_e'(SELECTOR))
            PROG_NORMAL, PROG_HEAVY: rinse_d = RINSE_W'(RINSES);
            default:                 rinse_d = RINSE_W'(1);
          endcase
        end
      end
      ST_PAUSED: begin
        if (START && !PAUSE) state_d = saved_q;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        // Active phases: door loss beats pause, pause beats completion
        tmr_en = 1'b1;
        if (!DOOR_CLOSED) begin
          state_d = ST_FAULT;
        end else if (PAUSE) begin
          state_d = ST_PAUSED;
          saved_d = state_q;
        end else begin
          case (state_q)
            ST_FILL: begin
              if (WATER_LEVEL_SENSOR) begin
                first_d = 1'b0;
                if (!first_q) begin
                  state_d = ST_RINSE;
                end else begin
                  case (prog_q)
                    PROG_QUICK:      state_d = ST_WASH;
                    PROG_RINSE_SPIN: state_d = ST_RINSE;
                    default:         state_d = ST_HEAT;
                  endcase
                end
              end else if (tmr_at_term_c) begin
                state_d = ST_FAULT;
              end
            end
            ST_HEAT: begin
              if (TEMP_SENSOR)        state_d = ST_WASH;
              else if (tmr_at_term_c) state_d = ST_FAULT;
            end
            ST_WASH: begin
              if (tmr_at_term_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
              if (tmr_at_term_c) state_d = (rinse_q != '0) ? ST_FILL : ST_SPIN;
            end
            ST_RINSE: begin
              if (tmr_at_term_c) begin
                state_d = ST_DRAIN;
                if (rinse_q != '0) rinse_d = rinse_q - RINSE_W'(1);
              end
            end
            ST_SPIN: begin
              if (tmr_at_term_c) state_d = ST_DONE;
            end
            default: state_d = state_q;
          endcase
        end
      end
    endcase

    // Pause entry/exit keeps the count; every other state change restarts it
    tmr_clr = (state_d != state_q) && (state_d != ST_PAUSED) && (state_q != ST_PAUSED);
    act_d   = act_decode(state_d, first_d && (prog_d != PROG_RINSE_SPIN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      prog_q  <= PROG_QUICK;
      first_q <= 1'b0;
      rinse_q <= '0;
      act_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      prog_q  <= prog_d;
      first_q <= first_d;
      rinse_q <= rinse_d;
      act_q   <= act_d;
      done_q  <= (state_d == ST_DONE);
      fault_q <= (state_d == ST_FAULT);
    end
  end

  assign DOOR_LOCK       = act_q.door_lock;
  assign WATER_VALVE     = act_q.water_valve;
  assign DETERGENT_HATCH = act_q.detergent_hatch;
  assign WATER_HEATER    = act_q.water_heater;
  assign DRUM_MOTOR      = act_q.drum_motor;
  assign WATER_PUMP      = act_q.water_pump;
  assign CURRENT_STATE   = state_q;
  assign RINSE_LEFT      = rinse_q;
  assign DONE            = done_q;
  assign FAULT           = fault_q;

endmodule

// File: tb/tb_wm_program_controller.sv
// Scoreboarded bench for wm_program_controller: a programme-level model queues the
// expected phase sequence, a plant drives the sensors, a monitor checks each phase.
module tb_wm_program_controller;

  localparam int FILL_TMO = 100;
  localparam int HEAT_TMO = 100;
  localparam int RINSES   = 2;
  localparam int WASH_N   = 40;
  localparam int RINSE_N  = 20;
  localparam int DRAIN_N  = 10;
  localparam int SPIN_N   = 30;
  localparam int PAUSE_N  = 50;

  localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_HEAT = 4'd2, S_WASH = 4'd3,
                         S_DRAIN = 4'd4, S_RINSE = 4'd5, S_SPIN = 4'd6, S_DONE = 4'd7,
                         S_PAUSED = 4'd8, S_FAULT = 4'd9;

  // observation bits: {DONE,FAULT,LOCK,VALVE,HATCH,HEATER,MOTOR,PUMP}
  localparam logic [7:0] O_IDLE = 8'b0000_0000, O_FILL1 = 8'b0011_1000, O_FILL = 8'b0011_0000,
                         O_HEAT = 8'b0010_0100, O_MOTOR = 8'b0010_0010, O_DRAIN = 8'b0010_0001,
                         O_SPIN = 8'b0010_0011, O_DONE = 8'b1000_0000, O_PAUSED = 8'b0010_0000,
                         O_FAULT = 8'b0110_0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] SELECTOR;
  logic       START, PAUSE, DOOR_CLOSED, WATER_LEVEL_SENSOR, TEMP_SENSOR;
  logic       DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR, WATER_PUMP;
  logic [3:0] CURRENT_STATE;
  logic [2:0] RINSE_LEFT;
  logic       DONE, FAULT;

  wm_program_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .SELECTOR           (SELECTOR),
    .START              (START),
    .PAUSE              (PAUSE),
    .DOOR_CLOSED        (DOOR_CLOSED),
    .WATER_LEVEL_SENSOR (WATER_LEVEL_SENSOR),
    .TEMP_SENSOR        (TEMP_SENSOR),
    .DOOR_LOCK          (DOOR_LOCK),
    .WATER_VALVE        (WATER_VALVE),
    .DETERGENT_HATCH    (DETERGENT_HATCH),
    .WATER_HEATER       (WATER_HEATER),
    .DRUM_MOTOR         (DRUM_MOTOR),
    .WATER_PUMP         (WATER_PUMP),
    .CURRENT_STATE      (CURRENT_STATE),
    .RINSE_LEFT         (RINSE_LEFT),
    .DONE               (DONE),
    .FAULT              (FAULT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] len;
    logic [7:0]  obs;
    logic [2:0]  rl;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   fill_d[8];
  int   heat_d;
  bit   mon_en = 1'b0;
  bit   model_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push(input logic [3:0] st, input int len, input logic [7:0] obs, input int rl);
    seg_t s;
    s.st  = st;
    s.len = 32'(len);
    s.obs = obs;
    s.rl  = 3'(rl);
    exp_q.push_back(s);
  endtask

  task automatic model_fill(input bit hatch, input int rl, inout int fi, output bit faulted);
    int d;
    d = fill_d[fi];
    fi++;
    faulted = 1'b0;
    if (d > FILL_TMO) begin
      push(S_FILL, FILL_TMO, hatch ? O_FILL1 : O_FILL, rl);
      push(S_FAULT, 0, O_FAULT, rl);
      faulted = 1'b1;
      model_fault = 1'b1;
    end else begin
      push(S_FILL, d, hatch ? O_FILL1 : O_FILL, rl);
    end
  endtask

  task automatic build_model(input int prog, input int pause_p, input int spin_q, input int heat_r);
    int rl, fi, wl;
    bit f;
    model_fault = 1'b0;
    fi = 0;
    push(S_IDLE, 0, O_IDLE, 0);
    rl = (prog == 1 || prog == 2) ? RINSES : 1;
    model_fill(prog != 3, rl, fi, f);
    if (f) return;
    if (prog != 3) begin
      if (prog == 1 || prog == 2) begin
        if (heat_r > 0) begin
          push(S_HEAT, heat_r, O_HEAT, rl);
          push(S_IDLE, 0, O_IDLE, 0);
          return;
        end
        if (heat_d > HEAT_TMO) begin
          push(S_HEAT, HEAT_TMO, O_HEAT, rl);
          push(S_FAULT, 0, O_FAULT, rl);
          model_fault = 1'b1;
          return;
        end
        push(S_HEAT, heat_d, O_HEAT, rl);
      end
      wl = (prog == 2) ? 2 * WASH_N : WASH_N;
      if (pause_p > 0) begin
        push(S_WASH, pause_p, O_MOTOR, rl);
        push(S_PAUSED, PAUSE_N, O_PAUSED, rl);
        push(S_WASH, wl - pause_p, O_MOTOR, rl);
      end else begin
        push(S_WASH, wl, O_MOTOR, rl);
      end
      push(S_DRAIN, DRAIN_N, O_DRAIN, rl);
    end else begin
      push(S_RINSE, RINSE_N, O_MOTOR, rl);
      rl--;
      push(S_DRAIN, DRAIN_N, O_DRAIN, rl);
    end
    while (rl > 0) begin
      model_fill(1'b0, rl, fi, f);
      if (f) return;
      push(S_RINSE, RINSE_N, O_MOTOR, rl);
      rl--;
      push(S_DRAIN, DRAIN_N, O_DRAIN, rl);
    end
    if (spin_q > 0) begin
      push(S_SPIN, spin_q, O_SPIN, 0);
      push(S_FAULT, 0, O_FAULT, 0);
      model_fault = 1'b1;
      return;
    end
    push(S_SPIN, SPIN_N, O_SPIN, 0);
    push(S_DONE, 1, O_DONE, 0);
    push(S_IDLE, 0, O_IDLE, 0);
  endtask

  // ---------------- plant: level/temperature rise after valve/heater time ----------------
  int p_vcnt, p_hcnt, p_fidx;
  always @(negedge clk) begin
    if (!rst_n || CURRENT_STATE == S_IDLE) begin
      p_vcnt = 0;
      p_hcnt = 0;
      p_fidx = 0;
    end else begin
      if (WATER_VALVE) p_vcnt++;
      else if (p_vcnt != 0) begin
        p_vcnt = 0;
        if (p_fidx < 7) p_fidx++;
      end
      if (WATER_HEATER) p_hcnt++;
      else p_hcnt = 0;
    end
    WATER_LEVEL_SENSOR = (p_vcnt != 0) && (p_vcnt >= fill_d[p_fidx]);
    TEMP_SENSOR        = (p_hcnt != 0) && (p_hcnt >= heat_d);
  end

  // ---------------- monitor ----------------
  seg_t       cur;
  bit         have_cur = 1'b0;
  int         seg_cnt, seg_bad;
  logic [7:0] obs;
  always @(negedge clk) begin
    if (!mon_en) begin
      have_cur = 1'b0;
    end else begin
      obs = {DONE, FAULT, DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR, WATER_PUMP};
      if (have_cur && CURRENT_STATE == cur.st) begin
        seg_cnt++;
        if (obs != cur.obs || RINSE_LEFT != cur.rl) seg_bad++;
      end else begin
        if (have_cur) begin
          if (cur.len != 0) chk("phase_len", 32'(seg_cnt), cur.len);
          chk("phase_steady_outputs", 32'(seg_bad), 32'd0);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_state actual=%0d required=none t=%0t", CURRENT_STATE, $time);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          chk("state", 32'(CURRENT_STATE), 32'(cur.st));
          chk("outputs", 32'(obs), 32'(cur.obs));
          chk("rinse_left", 32'(RINSE_LEFT), 32'(cur.rl));
          seg_cnt  = 1;
          seg_bad  = 0;
          have_cur = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    START = 1'b0;
    PAUSE = 1'b0;
    DOOR_CLOSED = 1'b1;
    SELECTOR = 2'b00;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int prog, input int pause_p, input int spin_q, input int heat_r);
    int guard, settle, wcnt, pcnt, scnt, hcnt;
    bit pdone, rst_pend, rst_done;
    guard = 0; settle = 0; wcnt = 0; pcnt = 0; scnt = 0; hcnt = 0;
    pdone = 1'b0; rst_pend = 1'b0; rst_done = 1'b0;
    do_reset();
    build_model(prog, pause_p, spin_q, heat_r);
    mon_en = 1'b1;
    @(negedge clk);
    SELECTOR = 2'(prog);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    while (guard < 2000 && settle < 10) begin
      @(negedge clk);
      guard++;
      SELECTOR = 2'($urandom);
      START = 1'b0;
      if (rst_pend) begin
        rst_n = 1'b1;
        rst_pend = 1'b0;
      end
      case (CURRENT_STATE)
        S_WASH: begin
          wcnt++;
          if (pause_p > 0 && !pdone && wcnt == pause_p) PAUSE = 1'b1;
        end
        S_PAUSED: begin
          pcnt++;
          if (pcnt == PAUSE_N) begin
            PAUSE = 1'b0;
            START = 1'b1;
            pdone = 1'b1;
          end
        end
        S_SPIN: begin
          scnt++;
          if (spin_q > 0 && scnt == spin_q) DOOR_CLOSED = 1'b0;
        end
        S_HEAT: begin
          hcnt++;
          if (heat_r > 0 && !rst_done && hcnt == heat_r) begin
            rst_n = 1'b0;
            rst_pend = 1'b1;
            rst_done = 1'b1;
          end
        end
        default: ;
      endcase
      if (exp_q.size() == 0) settle++;
    end
    chk("run_complete_pending", 32'(exp_q.size()), 32'd0);
    if (model_fault) begin
      // FAULT must hold until reset, then reset clears everything
      chk("fault_hold_state", 32'(CURRENT_STATE), 32'(S_FAULT));
      chk("fault_hold_flag", 32'(FAULT), 32'd1);
      chk("fault_hold_pump", 32'(WATER_PUMP), 32'd1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("fault_reset_state", 32'(CURRENT_STATE), 32'(S_IDLE));
      chk("fault_reset_outputs", 32'({DONE, FAULT, DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH,
                                      WATER_HEATER, DRUM_MOTOR, WATER_PUMP}), 32'd0);
      rst_n = 1'b1;
    end
    mon_en = 1'b0;
  endtask

  task automatic set_fills(input int d);
    for (int i = 0; i < 8; i++) fill_d[i] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    START = 1'b0;
    PAUSE = 1'b0;
    DOOR_CLOSED = 1'b1;
    SELECTOR = 2'b00;
    heat_d = 5;
    set_fills(5);

    // quick programme
    set_fills(5);
    run(0, 0, 0, 0);
    // normal programme with heat and two rinses
    set_fills(3); heat_d = 7;
    run(1, 0, 0, 0);
    // fill timeout and its boundary
    set_fills(5); fill_d[0] = FILL_TMO + 1;
    run(0, 0, 0, 0);
    set_fills(5); fill_d[0] = FILL_TMO;
    run(0, 0, 0, 0);
    // heat timeout and its boundary
    set_fills(4); heat_d = HEAT_TMO + 1;
    run(2, 0, 0, 0);
    heat_d = HEAT_TMO;
    run(1, 0, 0, 0);
    // pause in WASH, including a pause on the last-but-one cycle of a heavy wash
    set_fills(6); heat_d = 3;
    run(0, 16, 0, 0);
    run(2, 79, 0, 0);
    // door lost during SPIN
    run(3, 0, 10, 0);
    // reset during HEAT
    heat_d = 1000;
    run(1, 0, 0, 4);

    // START with the door open is ignored
    do_reset();
    DOOR_CLOSED = 1'b0;
    push(S_IDLE, 0, O_IDLE, 0);
    mon_en = 1'b1;
    @(negedge clk);
    START = 1'b1;
    repeat (3) @(negedge clk);
    START = 1'b0;
    repeat (3) @(negedge clk);
    chk("door_open_idle_state", 32'(CURRENT_STATE), 32'(S_IDLE));
    chk("door_open_idle_lock", 32'(DOOR_LOCK), 32'd0);
    mon_en = 1'b0;

    // randomized programmes
    for (int r = 0; r < 10; r++) begin
      int prog, pp;
      for (int i = 0; i < 8; i++) fill_d[i] = 1 + int'($urandom_range(19, 0));
      heat_d = 1 + int'($urandom_range(19, 0));
      prog = int'($urandom_range(3, 0));
      pp = 0;
      if (prog != 3 && $urandom_range(1, 0) == 1) pp = 1 + int'($urandom_range(38, 0));
      run(prog, pp, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
